// File: rtl/gsim_residual_check.sv
// gsim_residual_check: recomputes b - A*x for the banded GSIM system.
// Snoops the b stream and the solver's x words, then scans the rows.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-low reset
//   in_en, b_in    b stream, integer b values, 16 beats per run
//   out_valid      solver result valid, x_out = Q16.16 x[0..15]
//   done           one-cycle pulse when results are final
//   pass           max_res <= TOL
//   max_res        max |r_k|, unsigned Q16.16, saturating
//   worst_idx      row holding max_res (lowest index on ties)
// N must be a power of two.
module gsim_residual_check #(
  parameter int          N   = 16,
  parameter logic [31:0] TOL = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [15:0] b_in,
  input  logic        out_valid,
  input  logic [31:0] x_out,
  output logic        done,
  output logic        pass,
  output logic [31:0] max_res,
  output logic [3:0]  worst_idx
);

  localparam int IW = $clog2(N);

  localparam logic signed [IW+1:0] D1 = 1;
  localparam logic signed [IW+1:0] D2 = 2;
  localparam logic signed [IW+1:0] D3 = 3;

  typedef enum logic [2:0] {
    IDLE, LOAD_B, WAIT_X, LOAD_X,
    COMPUTE, DONE, HOLD
  } state_t;

  state_t state, nxt;

  logic signed [15:0] bbuf [N];
  logic signed [31:0] xbuf [N];

  logic [IW-1:0] bcnt, xcnt, kcnt;
  logic [31:0]   run_max;
  logic [IW-1:0] run_idx;

  logic restart, done_nx;
  logic last_b, last_x, last_k;

  logic signed [IW+1:0] kk;
  logic signed [39:0]   xc, s1, s2, s3;
  logic signed [39:0]   ax, bw, res;
  logic [39:0]          mag;
  logic [31:0]          mag_sat;

  // Neighbour fetch; two guard bits flag indices outside 0..N-1.
  function automatic logic signed [39:0] xat(
    input logic signed [IW+1:0] j
  );
    if (j[IW+1:IW] != 2'b00) return '0;
    return {{8{xbuf[j[IW-1:0]][31]}}, xbuf[j[IW-1:0]]};
  endfunction

  assign last_b = (bcnt == IW'(N-1));
  assign last_x = (xcnt == IW'(N-1));
  assign last_k = (kcnt == IW'(N-1));

  // Row k: 20x - 13(x-1 + x+1) + 6(x-2 + x+2) - (x-3 + x+3)
  always_comb begin
    kk = $signed({2'b00, kcnt});
    xc = xat(kk);
    s1 = xat(kk - D1) + xat(kk + D1);
    s2 = xat(kk - D2) + xat(kk + D2);
    s3 = xat(kk - D3) + xat(kk + D3);
    ax = (xc <<< 4) + (xc <<< 2)
       - ((s1 <<< 3) + (s1 <<< 2) + s1)
       + (s2 <<< 2) + (s2 <<< 1)
       - s3;
    bw = {{8{bbuf[kcnt][15]}}, bbuf[kcnt], 16'h0};
    res = bw - ax;
    mag = res[39] ? $unsigned(-res) : $unsigned(res);
    mag_sat = (|mag[39:32]) ? 32'hFFFF_FFFF : mag[31:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (restart) begin
      nxt = LOAD_B;
    end else begin
      unique case (state)
        IDLE:    nxt = IDLE;
        LOAD_B:  if (!in_en || last_b) nxt = WAIT_X;
        WAIT_X:  if (out_valid) nxt = LOAD_X;
        LOAD_X:  if (out_valid && last_x) nxt = COMPUTE;
        COMPUTE: if (last_k) nxt = DONE;
        DONE:    nxt = HOLD;
        HOLD:    nxt = HOLD;
        default: nxt = IDLE;
      endcase
    end
  end

  // Any b beat outside LOAD_B starts a fresh run.
  always_comb begin
    restart = in_en && (state != LOAD_B);
    done_nx = (state == DONE) && !restart;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        bbuf[i] <= '0;
        xbuf[i] <= '0;
      end
      bcnt      <= '0;
      xcnt      <= '0;
      kcnt      <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      max_res   <= '0;
      worst_idx <= '0;
    end else begin
      done <= done_nx;
      if (restart) begin
        bbuf[0]   <= b_in;
        bcnt      <= IW'(1);
        pass      <= 1'b0;
        max_res   <= '0;
        worst_idx <= '0;
      end else begin
        unique case (state)
          LOAD_B: if (in_en) begin
            bbuf[bcnt] <= b_in;
            bcnt       <= bcnt + IW'(1);
          end
          WAIT_X: if (out_valid) begin
            xbuf[0] <= x_out;
            xcnt    <= IW'(1);
          end
          LOAD_X: if (out_valid) begin
            xbuf[xcnt] <= x_out;
            xcnt       <= xcnt + IW'(1);
            if (last_x) begin
              kcnt    <= '0;
              run_max <= '0;
              run_idx <= '0;
            end
          end
          COMPUTE: begin
            if (mag_sat > run_max) begin
              run_max <= mag_sat;
              run_idx <= kcnt;
            end
            kcnt <= kcnt + IW'(1);
          end
          DONE: begin
            max_res   <= run_max;
            worst_idx <= 4'(run_idx);
            pass      <= (run_max <= TOL);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gsim_residual_check.sv
// tb_gsim_residual_check: scoreboard bench for gsim_residual_check.
// Reference model evaluates the band matrix with plain integer math.
module tb_gsim_residual_check;

  localparam logic [31:0] TOL_TB = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_en = 1'b0;
  logic [15:0] b_in = '0;
  logic        out_valid = 1'b0;
  logic [31:0] x_out = '0;
  logic        done;
  logic        pass;
  logic [31:0] max_res;
  logic [3:0]  worst_idx;

  gsim_residual_check #(
    .N(16),
    .TOL(TOL_TB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_en(in_en),
    .b_in(b_in),
    .out_valid(out_valid),
    .x_out(x_out),
    .done(done),
    .pass(pass),
    .max_res(max_res),
    .worst_idx(worst_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] mr;
    logic [3:0]  wi;
    logic        p;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t lastexp;

  int errors = 0;
  int checks = 0;

  logic signed [15:0] bv [16];
  logic signed [15:0] mb [16];
  logic signed [31:0] xv [16];
  logic signed [31:0] mx [16];
  int                 xi [16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Residual of every row straight from the band coefficients.
  function automatic exp_t model(input int due);
    longint coef [7];
    longint ax, r, a;
    logic [31:0] s;
    exp_t e;
    coef = '{-1, 6, -13, 20, -13, 6, -1};
    e.mr = '0;
    e.wi = '0;
    e.due = due;
    for (int k = 0; k < 16; k++) begin
      ax = 0;
      for (int d = -3; d <= 3; d++)
        if (k + d >= 0 && k + d < 16)
          ax += coef[d+3] * longint'(mx[k+d]);
      r = longint'(mb[k]) * 65536 - ax;
      a = (r < 0) ? -r : r;
      s = (a > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(a);
      if (s > e.mr) begin
        e.mr = s;
        e.wi = 4'(k);
      end
    end
    e.p = (e.mr <= TOL_TB);
    return e;
  endfunction

  function automatic int axint(input int k);
    int coef [7];
    int acc;
    coef = '{-1, 6, -13, 20, -13, 6, -1};
    acc = 0;
    for (int d = -3; d <= 3; d++)
      if (k + d >= 0 && k + d < 16)
        acc += coef[d+3] * xi[k+d];
    return acc;
  endfunction

  always @(negedge clk) begin
    if (reset && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 at cycle %0d, required 0",
                 cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("max_res", max_res, e.mr);
        chk("worst_idx", {28'b0, worst_idx}, {28'b0, e.wi});
        chk("pass", {31'b0, pass}, {31'b0, e.p});
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic send_b(input int nb, input bit chk_clear);
    for (int i = 0; i < nb; i++) begin
      @(posedge clk);
      #1;
      in_en = 1'b1;
      b_in = bv[i];
      mb[i] = bv[i];
      if (chk_clear && i == 1) begin
        chk("clr_max", max_res, 32'h0);
        chk("clr_idx", {28'b0, worst_idx}, 32'h0);
        chk("clr_pass", {31'b0, pass}, 32'h0);
      end
    end
    @(posedge clk);
    #1;
    in_en = 1'b0;
  endtask

  task automatic send_x(input int extra, input bit gaps,
                        input bit expect_it);
    int gap;
    int i;
    gap = 1 + int'($urandom_range(0, 2));
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    i = 0;
    while (i < 16 + extra) begin
      if (gaps && i > 0 && i < 16 && $urandom_range(0, 3) == 0) begin
        out_valid = 1'b0;
        x_out = $urandom;
      end else begin
        out_valid = 1'b1;
        x_out = (i < 16) ? xv[i] : $urandom;
        if (i < 16) mx[i] = xv[i];
        if (i == 15 && expect_it) begin
          lastexp = model(cyc + 18);
          sbq.push_back(lastexp);
        end
        i++;
      end
      @(posedge clk);
      #1;
    end
    x_out = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, required 1",
               t);
      sbq.delete();
    end
    #1;
    out_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_max", max_res, lastexp.mr);
  endtask

  task automatic run(input int nb, input int extra,
                     input bit gaps, input bit chk_clear);
    send_b(nb, chk_clear);
    send_x(extra, gaps, 1'b1);
    drain();
  endtask

  task automatic zero_vec();
    for (int i = 0; i < 16; i++) begin
      bv[i] = '0;
      xv[i] = '0;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mb[i] = '0;
      mx[i] = '0;
      xi[i] = 0;
    end
    zero_vec();
    lastexp = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_pass", {31'b0, pass}, 32'h0);
    chk("rst_max", max_res, 32'h0);
    chk("rst_idx", {28'b0, worst_idx}, 32'h0);
    reset = 1'b1;

    // all zero
    run(16, 0, 1'b0, 1'b0);

    // single unit b
    bv[0] = 16'sd1;
    run(16, 0, 1'b0, 1'b0);
    bv[0] = 16'sd2;
    run(16, 0, 1'b0, 1'b0);

    // exact solution with unit x[7]
    zero_vec();
    bv[4] = -16'sd1;  bv[5] = 16'sd6;
    bv[6] = -16'sd13; bv[7] = 16'sd20;
    bv[8] = -16'sd13; bv[9] = 16'sd6;
    bv[10] = -16'sd1;
    xv[7] = 32'h0001_0000;
    run(16, 0, 1'b0, 1'b1);

    // saturation
    zero_vec();
    for (int i = 0; i < 16; i++) xv[i] = 32'h7FFF_FFFF;
    run(16, 0, 1'b0, 1'b0);

    // tie at the tolerance, extra out_valid words
    zero_vec();
    bv[3] = 16'sd1;
    bv[9] = 16'sd1;
    run(16, 14, 1'b0, 1'b1);

    // partial b load keeps old tail
    for (int i = 0; i < 16; i++) begin
      bv[i] = 16'($urandom_range(0, 7));
      xv[i] = 32'($urandom_range(0, 32'h3FFFF));
    end
    run(8, 0, 1'b1, 1'b1);

    for (int t = 0; t < 24; t++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 16; i++)
        xi[i] = int'($urandom_range(0, 100)) - 50;
      for (int i = 0; i < 16; i++) begin
        if (mode == 0) begin
          xv[i] = 32'($urandom);
          bv[i] = 16'($urandom);
        end else begin
          xv[i] = 32'(xi[i] * 65536);
          if (mode == 1)
            xv[i] = xv[i] + 32'(int'($urandom_range(0, 8191)) - 4096);
        end
      end
      if (mode != 0)
        for (int k = 0; k < 16; k++)
          bv[k] = 16'(axint(k) + ((mode == 2 && $urandom_range(0, 3) == 0)
                                  ? 1 : 0));
      run(16, int'($urandom_range(0, 10)), 1'b1, 1'b1);
    end

    // reset while computing
    for (int i = 0; i < 16; i++) begin
      bv[i] = 16'($urandom);
      xv[i] = 32'($urandom);
    end
    send_b(16, 1'b0);
    send_x(0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_done", {31'b0, done}, 32'h0);
    chk("mid_rst_pass", {31'b0, pass}, 32'h0);
    chk("mid_rst_max", max_res, 32'h0);
    chk("mid_rst_idx", {28'b0, worst_idx}, 32'h0);
    reset = 1'b1;
    out_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mb[i] = '0;
      mx[i] = '0;
    end
    repeat (30) @(posedge clk);
    #1;

    // buffers cleared by reset: short b load
    for (int i = 0; i < 16; i++) begin
      bv[i] = 16'($urandom_range(1, 9));
      xv[i] = 32'($urandom_range(0, 32'hFFFF));
    end
    run(4, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
